// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl
// Brief    : Memory-mapped switches, debounced buttons with sticky events and
//            a scanned multi-digit hex display on the MIPS data-memory bus.
// Revision : 1.0  initial release
// ============================================================================
module mmio_io_ctrl #(
    parameter int          NUM_DIGITS      = 8,
    parameter int          SW_WIDTH        = 16,
    parameter int          NUM_BTN         = 3,
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter int          SCAN_DIV        = 50000,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_FF00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  memwrite,
    input  logic [31:0]           dataadr,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [SW_WIDTH-1:0]   SW,
    input  logic [NUM_BTN-1:0]    BTN,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            A2G,
    output logic                  DP
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_SC_W-1:0]  c_SC_MAX  = c_SC_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);

    localparam logic [7:0] c_OFF_SW   = 8'h00;
    localparam logic [7:0] c_OFF_LVL  = 8'h04;
    localparam logic [7:0] c_OFF_EVT  = 8'h08;
    localparam logic [7:0] c_OFF_DATA = 8'h0C;
    localparam logic [7:0] c_OFF_CTRL = 8'h10;

    // Bus decode
    logic       w_sel;
    logic       w_wr;
    logic [7:0] w_off;

    assign w_sel = (dataadr[31:8] == BASE_ADDR[31:8]);
    assign w_wr  = memwrite & w_sel;
    assign w_off = dataadr[7:0];

    // Input synchronisers
    logic [SW_WIDTH-1:0] r_sw_meta, r_sw_sync;
    logic [NUM_BTN-1:0]  r_btn_meta, r_btn_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= BTN;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debounce and sticky events
    logic [c_DB_W-1:0]  r_db_cnt  [NUM_BTN];
    logic [c_DB_W-1:0]  w_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] r_btn_level, w_level_nxt;
    logic [NUM_BTN-1:0] r_btn_evt, w_evt_clr, w_rise;

    always_comb begin
        w_level_nxt = r_btn_level;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_btn_sync[i] != r_btn_level[i]) begin
                if (r_db_cnt[i] == c_DB_MAX) begin
                    w_level_nxt[i] = r_btn_sync[i];
                end else begin
                    w_cnt_nxt[i] = r_db_cnt[i] + c_DB_W'(1);
                end
            end
        end
    end

    assign w_rise    = w_level_nxt & ~r_btn_level;
    assign w_evt_clr = (w_wr && (w_off == c_OFF_EVT)) ? writedata[NUM_BTN-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_btn_level <= '0;
            r_btn_evt   <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt[i] <= w_cnt_nxt[i];
            end
            r_btn_level <= w_level_nxt;
            // A new press outranks a simultaneous clear
            r_btn_evt   <= (r_btn_evt & ~w_evt_clr) | w_rise;
        end
    end

    // Display registers
    logic [4*NUM_DIGITS-1:0] r_disp_data;
    logic [NUM_DIGITS-1:0]   r_en, r_dpm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_data <= '0;
            r_en        <= '1;
            r_dpm       <= '0;
        end else if (w_wr) begin
            if (w_off == c_OFF_DATA) begin
                r_disp_data <= writedata[4*NUM_DIGITS-1:0];
            end
            if (w_off == c_OFF_CTRL) begin
                r_en  <= writedata[NUM_DIGITS-1:0];
                r_dpm <= writedata[8 +: NUM_DIGITS];
            end
        end
    end

    // Read mux
    always_comb begin
        readdata = '0;
        if (w_sel) begin
            case (w_off)
                c_OFF_SW:   readdata[SW_WIDTH-1:0]     = r_sw_sync;
                c_OFF_LVL:  readdata[NUM_BTN-1:0]      = r_btn_level;
                c_OFF_EVT:  readdata[NUM_BTN-1:0]      = r_btn_evt;
                c_OFF_DATA: readdata[4*NUM_DIGITS-1:0] = r_disp_data;
                c_OFF_CTRL: begin
                    readdata[NUM_DIGITS-1:0]  = r_en;
                    readdata[8 +: NUM_DIGITS] = r_dpm;
                end
                default: ;
            endcase
        end
    end

    // Digit scan
    logic [c_SC_W-1:0]  r_scan_cnt;
    logic [c_IDX_W-1:0] r_scan_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == c_SC_MAX) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == c_IDX_MAX) ? '0 : r_scan_idx + c_IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SC_W'(1);
        end
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'b0000001;
            4'h1: hex_seg = 7'b1001111;
            4'h2: hex_seg = 7'b0010010;
            4'h3: hex_seg = 7'b0000110;
            4'h4: hex_seg = 7'b1001100;
            4'h5: hex_seg = 7'b0100100;
            4'h6: hex_seg = 7'b0100000;
            4'h7: hex_seg = 7'b0001111;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0000100;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b1100000;
            4'hC: hex_seg = 7'b0110001;
            4'hD: hex_seg = 7'b1000010;
            4'hE: hex_seg = 7'b0110000;
            default: hex_seg = 7'b0111000;
        endcase
    endfunction

    logic [3:0]            w_nib;
    logic                  w_dig_en;
    logic                  w_dig_dp;
    logic [NUM_DIGITS-1:0] w_an_n;

    always_comb begin
        w_nib    = '0;
        w_dig_en = 1'b0;
        w_dig_dp = 1'b0;
        w_an_n   = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_scan_idx == c_IDX_W'(d)) begin
                w_nib     = r_disp_data[4*d +: 4];
                w_dig_en  = r_en[d];
                w_dig_dp  = r_dpm[d];
                w_an_n[d] = 1'b0;
            end
        end
    end

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_a2g;
    logic                  r_dp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= '1;
            r_a2g <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_dig_en) begin
            r_an  <= w_an_n;
            r_a2g <= hex_seg(w_nib);
            r_dp  <= ~w_dig_dp;
        end else begin
            r_an  <= '1;
            r_a2g <= 7'h7F;
            r_dp  <= 1'b1;
        end
    end

    assign AN  = r_an;
    assign A2G = r_a2g;
    assign DP  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_io_ctrl
// Brief    : Scoreboard bench for mmio_io_ctrl with a behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_io_ctrl;

    localparam int ND  = 8;
    localparam int SWW = 16;
    localparam int NB  = 3;
    localparam int DB  = 4;
    localparam int SD  = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           memwrite;
    logic [31:0]    dataadr;
    logic [31:0]    writedata;
    logic [31:0]    readdata;
    logic [SWW-1:0] SW;
    logic [NB-1:0]  BTN;
    logic [ND-1:0]  AN;
    logic [6:0]     A2G;
    logic           DP;

    mmio_io_ctrl #(
        .NUM_DIGITS     (ND),
        .SW_WIDTH       (SWW),
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .SCAN_DIV       (SD),
        .BASE_ADDR      (32'h0000_FF00)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .readdata (readdata),
        .SW       (SW),
        .BTN      (BTN),
        .AN       (AN),
        .A2G      (A2G),
        .DP       (DP)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [15:0] OFF_DISP = 16'hFFFF;  // {AN, A2G, DP} of a dark slot

    logic [SWW-1:0] m_sw_d1, m_sw_d2;
    logic [NB-1:0]  m_btn_d1, m_btn_d2;
    int             m_run [NB];
    logic [NB-1:0]  m_lvl, m_evt, m_set, m_clr;
    logic [31:0]    m_data;
    logic [7:0]     m_en, m_dpm;
    int             m_t, m_idx;
    logic [15:0]    m_exp;

    logic [15:0] exp_disp [$];
    logic [31:0] exp_rd   [$];
    logic        rd_pend = 1'b0;

    task automatic m_reset();
        m_sw_d1 = '0; m_sw_d2 = '0; m_btn_d1 = '0; m_btn_d2 = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        m_lvl = '0; m_evt = '0; m_data = '0; m_en = 8'hFF; m_dpm = '0; m_t = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:8] != 24'h0000FF) return 32'h0;
        case (a[7:0])
            8'h00:   return {16'h0, m_sw_d2};
            8'h04:   return {29'h0, m_lvl};
            8'h08:   return {29'h0, m_evt};
            8'h0C:   return m_data;
            8'h10:   return {16'h0, m_dpm, m_en};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reset();
            exp_disp.delete();
            exp_disp.push_back(OFF_DISP);
        end else begin
            // display slot shown after this edge comes from the pre-edge state
            m_idx = (m_t / SD) % ND;
            if (m_en[m_idx])
                m_exp = {~(8'd1 << m_idx), hex_tab[m_data[4*m_idx +: 4]], ~m_dpm[m_idx]};
            else
                m_exp = OFF_DISP;
            exp_disp.push_back(m_exp);
            m_t++;
            // a level flips after DB consecutive samples disagreeing with it
            m_set = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_btn_d2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) m_set[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_clr = '0;
            if (memwrite && dataadr[31:8] == 24'h0000FF) begin
                case (dataadr[7:0])
                    8'h08: m_clr = writedata[NB-1:0];
                    8'h0C: m_data = writedata;
                    8'h10: begin m_en = writedata[7:0]; m_dpm = writedata[15:8]; end
                    default: ;
                endcase
            end
            m_evt = (m_evt & ~m_clr) | m_set;
            m_sw_d2 = m_sw_d1; m_sw_d1 = SW;
            m_btn_d2 = m_btn_d1; m_btn_d1 = BTN;
        end
    end

    // Monitor
    logic [15:0] mon_d;
    logic [31:0] mon_r;
    always @(negedge clk) begin
        if (exp_disp.size() > 0) begin
            mon_d = exp_disp.pop_front();
            chk("disp{AN,A2G,DP}", {16'h0, AN, A2G, DP}, {16'h0, mon_d});
        end
        if (rd_pend) begin
            if (exp_rd.size() > 0) begin
                mon_r = exp_rd.pop_front();
                chk("readdata", readdata, mon_r);
            end else begin
                chk("rd_queue_empty", 32'h1, 32'h0);
            end
        end
    end

    // Stimulus helpers (all driving happens 1 time unit after a rising edge)
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        cyc(1);
        memwrite = 1'b0; writedata = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        memwrite = 1'b0; dataadr = a;
        exp_rd.push_back(model_read(a));
        rd_pend = 1'b1;
        cyc(1);
        rd_pend = 1'b0;
    endtask

    logic [31:0] r_addrs [7] = '{32'h0000_FF00, 32'h0000_FF04, 32'h0000_FF08,
                                 32'h0000_FF0C, 32'h0000_FF10, 32'h0000_FF14,
                                 32'h0001_FF00};

    initial begin
        reset_n = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        SW = '0; BTN = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        cyc(1);

        // reset state and switch path
        rd(32'h0000_FF04);
        rd(32'h0000_FF08);
        rd(32'h0000_FF0C);
        rd(32'h0000_FF10);
        SW = 16'h1234;
        cyc(2);
        rd(32'h0000_FF00);
        chk("sw_direct", readdata, 32'h0000_1234);
        rd(32'h0000_FF14);
        rd(32'h0000_EF00);
        rd(32'h0000_FF02);
        wr(32'h0000_FF00, 32'hFFFF_FFFF);
        rd(32'h0000_FF00);

        // short bounce must not register
        BTN = 3'b100; cyc(3); BTN = 3'b000; cyc(8);
        rd(32'h0000_FF04);
        rd(32'h0000_FF08);
        // long press on buttons 0 and 2
        BTN = 3'b101; cyc(6);
        rd(32'h0000_FF04);
        BTN = 3'b000; cyc(8);
        rd(32'h0000_FF08);
        wr(32'h0000_FF08, 32'h1);
        rd(32'h0000_FF08);
        wr(32'h0000_FF08, 32'h0);
        rd(32'h0000_FF08);
        // clear of bit 2 lands on the same edge as its debounced rise
        wr(32'h0000_FF08, 32'h4);
        BTN = 3'b100; cyc(5);
        wr(32'h0000_FF08, 32'h4);
        rd(32'h0000_FF08);
        chk("evt_set_wins", readdata & 32'h4, 32'h4);
        BTN = 3'b000; cyc(8);

        // display walk
        wr(32'h0000_FF0C, 32'h89AB_CDEF);
        wr(32'h0000_FF10, 32'h0000_01FF);
        cyc(20);
        wr(32'h0000_FF10, 32'h0000_0005);
        cyc(20);
        wr(32'h0000_FF10, 32'hFFFF_FFFF);
        rd(32'h0000_FF10);
        rd(32'h0000_FF0C);

        // randomized traffic
        for (int it = 0; it < 700; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin BTN = NB'($urandom_range(0, 7)); cyc($urandom_range(1, 8)); end
                2:    begin SW = SWW'($urandom); cyc(1); end
                3:    wr(r_addrs[$urandom_range(0, 6)], $urandom);
                4:    wr(32'h0000_FF08, $urandom);
                5:    rd(r_addrs[$urandom_range(0, 6)] | {30'h0, 2'($urandom_range(0, 3))});
                default: rd(r_addrs[$urandom_range(0, 4)]);
            endcase
        end

        // asynchronous reset mid-scan while buttons are held
        wr(32'h0000_FF0C, 32'h1357_9BDF);
        wr(32'h0000_FF10, 32'h0000_FFFF);
        BTN = 3'b111; dataadr = 32'h0000_FF10;
        cyc(5);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_an",  {24'h0, AN}, 32'h0000_00FF);
        chk("rst_a2g", {25'h0, A2G}, 32'h0000_007F);
        chk("rst_dp",  {31'h0, DP}, 32'h1);
        chk("rst_ctrl", readdata, 32'h0000_00FF);
        dataadr = 32'h0000_FF0C;
        #1 chk("rst_data", readdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc(1);
        cyc(20);
        rd(32'h0000_FF04);
        rd(32'h0000_FF08);
        BTN = 3'b000;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
